adsr_envelope: RTL and testbench



---
 rtl/adsr_envelope.sv | 196 +++++++++++++++++++
 tb/tb_adsr_envelope.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
//   Per-sample ADSR amplitude envelope. Each accepted signed oscillator sample
//   is scaled by an unsigned envelope gain (max_env = 2^env_width_p - 1 ~ 1.0).
//   A note gate drives the attack/decay/sustain/release machine. All envelope
//   timing is counted in accepted samples, not clock cycles.
//
//   Optional feature macro: ADSR_HARD_RETRIGGER_EN
//     defined   : gate re-raised in RELEASE restarts the attack from env = 0
//     undefined : attack resumes from the current env (soft retrigger)
//
// Ports
//   clk_i    in   1        clock
//   reset_i  in   1        synchronous active-high reset
//   gate_i   in   1        note on/off, sampled only on accepted beats
//   valid_i  in   1        upstream sample valid
//   data_i   in   width_p  upstream signed sample
//   ready_o  out  1        block can accept a sample
//   valid_o  out  1        output sample valid (registered)
//   data_o   out  width_p  enveloped signed sample (registered)
//   ready_i  in   1        downstream ready
// -----------------------------------------------------------------------------
module adsr_envelope #(
  parameter int width_p         = 12,
  parameter int env_width_p     = 8,
  parameter int attack_step_p   = 4,
  parameter int decay_step_p    = 1,
  parameter int sustain_level_p = 192,
  parameter int release_step_p  = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               gate_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i
);

  localparam int prod_w_lp = width_p + env_width_p + 1;

  // One extra bit lets add/subtract detect overflow/borrow before clamping.
  typedef logic [env_width_p:0] env_ext_t;

  localparam env_ext_t max_env_lp      = {1'b0, {env_width_p{1'b1}}};
  localparam env_ext_t attack_step_lp  = env_ext_t'(attack_step_p);
  localparam env_ext_t decay_step_lp   = env_ext_t'(decay_step_p);
  localparam env_ext_t sustain_lp      = env_ext_t'(sustain_level_p);
  localparam env_ext_t release_step_lp = env_ext_t'(release_step_p);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [env_width_p-1:0]   env_q, env_d;
  logic                     valid_q;
  logic [width_p-1:0]       data_q;
  logic [width_p-1:0]       data_d;

  logic                     accept_s;
  logic                     fire_s;
  logic signed [prod_w_lp-1:0] data_ext_s;
  logic signed [prod_w_lp-1:0] env_ext_s;
  logic signed [prod_w_lp-1:0] product_s;
  logic                     unused_product_s;

  env_ext_t                 atk_sum_s;
  env_ext_t                 dec_diff_s;
  env_ext_t                 rel_diff_s;
  logic                     atk_sat_s;
  logic                     dec_floor_s;
  logic                     rel_floor_s;
  logic [env_width_p-1:0]   atk_first_s;

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign ready_o  = ~valid_q | ready_i;
  assign accept_s = valid_i & ready_o;
  assign fire_s   = valid_q & ready_i;

  // Signed sample times zero-extended gain; the gain used is the pre-update env.
  assign data_ext_s = {{(env_width_p + 1){data_i[width_p-1]}}, data_i};
  assign env_ext_s  = {{(width_p + 1){1'b0}}, env_q};
  assign product_s  = data_ext_s * env_ext_s;
  // Taking bits above env_width_p is the floor of an arithmetic shift.
  assign data_d     = product_s[env_width_p +: width_p];
  assign unused_product_s = ^{product_s[prod_w_lp-1], product_s[env_width_p-1:0]};

  // Saturating envelope arithmetic in env_width_p + 1 bits.
  assign atk_sum_s   = {1'b0, env_q} + attack_step_lp;
  assign dec_diff_s  = {1'b0, env_q} - decay_step_lp;
  assign rel_diff_s  = {1'b0, env_q} - release_step_lp;
  assign atk_sat_s   = (atk_sum_s >= max_env_lp);
  // Top bit set means the subtraction borrowed below zero.
  assign dec_floor_s = dec_diff_s[env_width_p] | (dec_diff_s <= sustain_lp);
  assign rel_floor_s = rel_diff_s[env_width_p] | (rel_diff_s == {(env_width_p + 1){1'b0}});
  assign atk_first_s = (attack_step_lp >= max_env_lp) ? max_env_lp[env_width_p-1:0]
                                                      : attack_step_lp[env_width_p-1:0];

  // Next envelope state and gain; only an accepted beat advances the envelope.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (accept_s) begin
      case (state_q)
        IDLE: begin
          if (gate_i) begin
            state_d = ATTACK;
            env_d   = atk_first_s;
          end else begin
            env_d   = {env_width_p{1'b0}};
          end
        end
        ATTACK: begin
          if (!gate_i) begin
            state_d = RELEASE;
          end else if (atk_sat_s) begin
            state_d = DECAY;
            env_d   = max_env_lp[env_width_p-1:0];
          end else begin
            env_d   = atk_sum_s[env_width_p-1:0];
          end
        end
        DECAY: begin
          if (!gate_i) begin
            state_d = RELEASE;
          end else if (dec_floor_s) begin
            state_d = SUSTAIN;
            env_d   = sustain_lp[env_width_p-1:0];
          end else begin
            env_d   = dec_diff_s[env_width_p-1:0];
          end
        end
        SUSTAIN: begin
          env_d = sustain_lp[env_width_p-1:0];
          if (!gate_i) begin
            state_d = RELEASE;
          end else begin
            state_d = SUSTAIN;
          end
        end
        RELEASE: begin
          if (gate_i) begin
            state_d = ATTACK;
`ifdef ADSR_HARD_RETRIGGER_EN
            env_d   = {env_width_p{1'b0}};
`else
            env_d   = env_q;
`endif
          end else if (rel_floor_s) begin
            state_d = IDLE;
            env_d   = {env_width_p{1'b0}};
          end else begin
            env_d   = rel_diff_s[env_width_p-1:0];
          end
        end
        default: begin
          state_d = IDLE;
          env_d   = {env_width_p{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
      env_d   = env_q;
    end
  end

  // Envelope state plus the one-entry output register; reset drops any in-flight beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      env_q   <= {env_width_p{1'b0}};
      valid_q <= 1'b0;
      data_q  <= {width_p{1'b0}};
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      if (accept_s) begin
        valid_q <= 1'b1;
        data_q  <= data_d;
      end else if (fire_s) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

  localparam int W    = 12;
  localparam int E    = 8;
  localparam int MAXE = 255;
  localparam int ATK  = 4;
  localparam int DEC  = 1;
  localparam int SUS  = 192;
  localparam int REL  = 2;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         gate_i = 1'b0;
  logic         valid_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         ready_i = 1'b1;

  int total = 0;
  int bad   = 0;

  // Scoreboard and reference envelope model (state: 0 idle,1 atk,2 dec,3 sus,4 rel).
  logic signed [W-1:0] sb_q[$];
  int m_st  = 0;
  int m_env = 0;

  always #5 clk = ~clk;

  adsr_envelope dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .gate_i  (gate_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  function automatic logic signed [W-1:0] predict(input logic [W-1:0] d, input int env);
    int di;
    int p;
    di = $signed(d);
    p  = di * env;
    p  = p >>> E;
    return p[W-1:0];
  endfunction

  // Monitor: at negedge, inputs/outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (reset_i) begin
      sb_q.delete();
      m_st  = 0;
      m_env = 0;
    end else begin
      if (valid_o && ready_i) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_output: got data_o=%0d with nothing expected", $signed(data_o));
        end else begin
          logic signed [W-1:0] e;
          e = sb_q.pop_front();
          if ($signed(data_o) !== e) begin
            bad++;
            $display("FAIL sb_data: data_o=%0d expected=%0d", $signed(data_o), e);
          end
        end
      end
      if (valid_i && ready_o) begin
        sb_q.push_back(predict(data_i, m_env));
        case (m_st)
          0: if (gate_i) begin m_st = 1; m_env = (ATK > MAXE) ? MAXE : ATK; end
             else m_env = 0;
          1: if (!gate_i) m_st = 4;
             else begin
               m_env = m_env + ATK;
               if (m_env >= MAXE) begin m_env = MAXE; m_st = 2; end
             end
          2: if (!gate_i) m_st = 4;
             else begin
               m_env = m_env - DEC;
               if (m_env <= SUS) begin m_env = SUS; m_st = 3; end
             end
          3: begin m_env = SUS; if (!gate_i) m_st = 4; end
          4: if (gate_i) begin
               m_st = 1;
`ifdef ADSR_HARD_RETRIGGER_EN
               m_env = 0;
`endif
             end else begin
               m_env = m_env - REL;
               if (m_env <= 0) begin m_env = 0; m_st = 0; end
             end
          default: m_st = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    gate_i  = 1'b0;
    ready_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    // Reset held while a beat is being offered.
    reset_i = 1'b1;
    valid_i = 1'b1;
    gate_i  = 1'b1;
    data_i  = 12'd2047;
    tick();
    tick();
    total++;
    if (valid_o !== 1'b0 || data_o !== 12'd0) begin
      bad++;
      $display("FAIL reset_out: valid_o=%0b data_o=%0d expected 0/0", valid_o, data_o);
    end
    total++;
    if (dut.env_q !== 8'd0 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_env: env=%0d ready_o=%0b expected 0/1", dut.env_q, ready_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_attack();
    valid_i = 1'b1;
    gate_i  = 1'b1;
    ready_i = 1'b1;
    data_i  = 12'd2047;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 1) begin
        total++;
        if (data_o !== 12'd0) begin bad++; $display("FAIL attack_first: data_o=%0d expected 0", data_o); end
      end
      if (k == 2) begin
        total++;
        if (data_o !== 12'd31) begin bad++; $display("FAIL attack_second: data_o=%0d expected 31", data_o); end
      end
      if (k == 63) begin
        total++;
        if (dut.env_q !== 8'd252) begin bad++; $display("FAIL attack_env63: env=%0d expected 252", dut.env_q); end
      end
      if (k == 64) begin
        total++;
        if (dut.env_q !== 8'd255) begin bad++; $display("FAIL attack_env64: env=%0d expected 255", dut.env_q); end
      end
    end
  endtask

  task automatic test_decay_sustain();
    for (int k = 1; k <= 63; k++) tick();
    total++;
    if (dut.env_q !== 8'd192) begin bad++; $display("FAIL decay_env: env=%0d expected 192", dut.env_q); end
    data_i = 12'd2047;
    tick();
    total++;
    if ($signed(data_o) !== 12'sd1535) begin bad++; $display("FAIL sustain_pos: data_o=%0d expected 1535", $signed(data_o)); end
    data_i = 12'h800;
    tick();
    total++;
    if ($signed(data_o) !== -12'sd1536) begin bad++; $display("FAIL sustain_neg: data_o=%0d expected -1536", $signed(data_o)); end
    data_i = 12'd2047;
  endtask

  task automatic test_release();
    gate_i = 1'b0;
    for (int k = 1; k <= 97; k++) tick();
    total++;
    if (dut.env_q !== 8'd0) begin bad++; $display("FAIL release_env: env=%0d expected 0", dut.env_q); end
    tick();
    tick();
    total++;
    if (data_o !== 12'd0) begin bad++; $display("FAIL release_idle_out: data_o=%0d expected 0", data_o); end
  endtask

  task automatic test_stall();
    do_reset();
    valid_i = 1'b1;
    gate_i  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_i = 12'(100 + 37 * k);
      tick();
    end
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      data_i = 12'(900 + k);
      tick();
      total++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
        bad++;
        $display("FAIL stall_hs: ready_o=%0b valid_o=%0b expected 0/1", ready_o, valid_o);
      end
      total++;
      if (dut.env_q !== 8'd40) begin bad++; $display("FAIL stall_env: env=%0d expected 40", dut.env_q); end
      total++;
      if (sb_q.size() != 1 || $signed(data_o) !== sb_q[0]) begin
        bad++;
        $display("FAIL stall_data: data_o=%0d queued=%0d", $signed(data_o), sb_q.size());
      end
    end
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_i = 12'(1500 - 11 * k);
      tick();
    end
    valid_i = 1'b0;
    tick();
    tick();
    total++;
    if (sb_q.size() != 0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_drain: queued=%0d valid_o=%0b expected 0/0", sb_q.size(), valid_o);
    end
  endtask

  task automatic test_retrigger();
    logic [7:0]  env1, env2;
    logic [11:0] out2, out3;
`ifdef ADSR_HARD_RETRIGGER_EN
    env1 = 8'd0;   env2 = 8'd4;   out2 = 12'd0;   out3 = 12'd31;
`else
    env1 = 8'd100; env2 = 8'd104; out2 = 12'd799; out3 = 12'd831;
`endif
    do_reset();
    valid_i = 1'b1;
    gate_i  = 1'b1;
    data_i  = 12'd2047;
    for (int k = 0; k < 130; k++) tick();
    gate_i = 1'b0;
    for (int k = 0; k < 200 && m_env != 100; k++) tick();
    total++;
    if (dut.env_q !== 8'd100) begin bad++; $display("FAIL retrig_reach: env=%0d expected 100", dut.env_q); end
    gate_i = 1'b1;
    tick();
    total++;
    if (dut.env_q !== env1 || data_o !== 12'd799) begin
      bad++;
      $display("FAIL retrig_beat: env=%0d data_o=%0d expected %0d/799", dut.env_q, data_o, env1);
    end
    tick();
    total++;
    if (dut.env_q !== env2 || data_o !== out2) begin
      bad++;
      $display("FAIL retrig_next: env=%0d data_o=%0d expected %0d/%0d", dut.env_q, data_o, env2, out2);
    end
    tick();
    total++;
    if (data_o !== out3) begin bad++; $display("FAIL retrig_ramp: data_o=%0d expected %0d", data_o, out3); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid_i = 1'b1;
    gate_i  = 1'b1;
    data_i  = 12'd2047;
    for (int k = 0; k < 130; k++) tick();
    reset_i = 1'b1;
    tick();
    total++;
    if (valid_o !== 1'b0 || data_o !== 12'd0 || dut.env_q !== 8'd0) begin
      bad++;
      $display("FAIL midreset: valid_o=%0b data_o=%0d env=%0d expected 0/0/0", valid_o, data_o, dut.env_q);
    end
    reset_i = 1'b0;
    tick();
    total++;
    if (data_o !== 12'd0) begin bad++; $display("FAIL midreset_first: data_o=%0d expected 0", data_o); end
    tick();
    total++;
    if (data_o !== 12'd31) begin bad++; $display("FAIL midreset_second: data_o=%0d expected 31", data_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      valid_i = 1'($urandom_range(0, 3) != 0);
      ready_i = 1'($urandom_range(0, 3) != 0);
      data_i  = 12'($urandom);
      if ($urandom_range(0, 39) == 0) gate_i = ~gate_i;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    tick();
    total++;
    if (sb_q.size() != 0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL random_drain: queued=%0d valid_o=%0b expected 0/0", sb_q.size(), valid_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_attack();
    test_decay_sustain();
    test_release();
    test_stall();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
